// File: rtl/jt10_adpcm_regwr.sv
// ADPCM-A channel control register writer: decodes CPU byte writes and hands each
// update to the 6-slot channel pipeline. Optional readback: JT10_ADPCM_RDBACK_EN.
module jt10_adpcm_regwr #(
    parameter int          NCH     = 6,
    parameter logic [2:0]  UP_IDLE = 3'd7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic [NCH-1:0] cur_ch,
    input  logic [7:0]     addr,
    input  logic [7:0]     din,
    input  logic           we,
    output logic [5:0]     atl,
    output logic [7:0]     lracl,
    output logic [2:0]     up_ch,
    output logic [NCH-1:0] kon,
    output logic [NCH-1:0] koff,
    output logic [NCH-1:0] pend,
    output logic [7:0]     dout
);

    logic [5:0]            atl_q;
    logic [NCH-1:0][7:0]   shadow_q;
    logic [NCH-1:0]        pend_q, pend_d;
    logic [NCH-1:0]        kon_q, kon_d;
    logic [NCH-1:0]        koff_q, koff_d;

    logic                  slot_ok;
    logic [2:0]            k;
    logic                  wr_key, wr_atl, wr_sh;
    logic [2:0]            sh_idx;

    assign wr_key = we && (addr == 8'h00);
    assign wr_atl = we && (addr == 8'h01);
    assign wr_sh  = we && (addr >= 8'h08) && (addr <= 8'h0D);
    assign sh_idx = addr[2:0];

    // A slot is only acted on when exactly one pipeline bit is set.
    always_comb begin
        slot_ok = ($countones(cur_ch) == 1);
        k       = 3'd0;
        for (int i = 0; i < NCH; i++)
            if (cur_ch[i]) k = i[2:0];
    end

    always_comb begin
        up_ch = UP_IDLE;
        lracl = 8'h00;
        kon   = '0;
        koff  = '0;
        if (slot_ok) begin
            lracl = shadow_q[k];
            if (pend_q[k]) up_ch = k;
            kon   = cur_ch & kon_q;
            koff  = cur_ch & koff_q;
        end
    end

    // Consumption is applied first so a same-clk write re-arms the channel.
    always_comb begin
        pend_d = pend_q;
        kon_d  = kon_q;
        koff_d = koff_q;
        if (cen && slot_ok) begin
            pend_d = pend_d & ~cur_ch;
            kon_d  = kon_d  & ~cur_ch;
            koff_d = koff_d & ~cur_ch;
        end
        if (wr_key) begin
            if (din[7]) koff_d = koff_d | din[5:0];
            else        kon_d  = kon_d  | din[5:0];
        end
        if (wr_sh) pend_d[sh_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            atl_q    <= 6'd0;
            shadow_q <= '0;
            pend_q   <= '0;
            kon_q    <= '0;
            koff_q   <= '0;
        end else begin
            pend_q <= pend_d;
            kon_q  <= kon_d;
            koff_q <= koff_d;
            if (wr_atl) atl_q <= din[5:0];
            if (wr_sh)  shadow_q[sh_idx] <= din;
        end
    end

    assign atl  = atl_q;
    assign pend = pend_q;

`ifdef JT10_ADPCM_RDBACK_EN
    logic [7:0] dout_q, dout_d;

    always_comb begin
        dout_d = 8'hFF;
        if (addr == 8'h00)      dout_d = {2'b00, kon_q | koff_q};
        else if (addr == 8'h01) dout_d = {2'b00, atl_q};
        else if ((addr >= 8'h08) && (addr <= 8'h0D)) dout_d = shadow_q[addr[2:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= 8'h00;
        else        dout_q <= dout_d;
    end

    assign dout = dout_q;
`else
    assign dout = 8'h00;
`endif

endmodule

// File: tb/tb_jt10_adpcm_regwr.sv
// Self-checking bench for jt10_adpcm_regwr: directed scenarios plus random writes
// against a per-channel reference model of pending updates and key strobes.
module tb_jt10_adpcm_regwr;

    logic       clk = 1'b0;
    logic       rst_n, cen, we;
    logic [5:0] cur_ch;
    logic [7:0] addr, din;
    logic [5:0] atl, kon, koff, pend;
    logic [7:0] lracl, dout;
    logic [2:0] up_ch;

    jt10_adpcm_regwr dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cur_ch(cur_ch), .addr(addr),
        .din(din), .we(we), .atl(atl), .lracl(lracl), .up_ch(up_ch),
        .kon(kon), .koff(koff), .pend(pend), .dout(dout)
    );

    always #5 clk = ~clk;

    // reference model
    logic [7:0] sh_m [6];
    bit         pend_m [6];
    bit         kon_m  [6];
    bit         koff_m [6];
    logic [5:0] atl_m;
    int         phase;
    int         npass, ntot;
    int         del_cnt [6];
    logic [7:0] del_val [6];
    int         kon_cnt [6];
    int         koff_cnt [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int slot_of(input logic [5:0] c);
        int n, idx;
        n = 0; idx = -1;
        for (int i = 0; i < 6; i++) if (c[i]) begin n++; idx = i; end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic logic [5:0] mask_of(input bit m [6]);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = m[i];
        return r;
    endfunction

    task automatic model_reset();
        atl_m = 6'd0;
        for (int i = 0; i < 6; i++) begin
            sh_m[i] = 8'h00; pend_m[i] = 0; kon_m[i] = 0; koff_m[i] = 0;
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 6; i++) begin
            del_cnt[i] = 0; del_val[i] = 8'h00; kon_cnt[i] = 0; koff_cnt[i] = 0;
        end
    endtask

    function automatic logic [7:0] rd_model(input logic [7:0] a);
`ifdef JT10_ADPCM_RDBACK_EN
        if (a == 8'h00) return {2'b00, mask_of(kon_m) | mask_of(koff_m)};
        if (a == 8'h01) return {2'b00, atl_m};
        if (a >= 8'h08 && a <= 8'h0D) return sh_m[a - 8'h08];
        return 8'hFF;
`else
        return (a == 8'hEE) ? 8'h00 : 8'h00;
`endif
    endfunction

    // One clk: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic cyc(input logic w, input logic [7:0] a, input logic [7:0] d);
        int k;
        logic c;
        logic [7:0] exp_dout;
        c = (phase == 2);
        phase = (phase + 1) % 3;
        we = w; addr = a; din = d; cen = c;
        @(negedge clk);
        k = slot_of(cur_ch);
        chk("up_ch", up_ch, (k >= 0 && pend_m[k]) ? k : 7);
        chk("kon",   kon,   (k >= 0) ? (cur_ch & mask_of(kon_m))  : 6'd0);
        chk("koff",  koff,  (k >= 0) ? (cur_ch & mask_of(koff_m)) : 6'd0);
        chk("pend",  pend,  mask_of(pend_m));
        chk("atl",   atl,   atl_m);
        if (k >= 0) chk("lracl", lracl, sh_m[k]);
        if (c) begin
            if (up_ch != 3'd7 && up_ch < 3'd6) begin
                del_cnt[up_ch]++; del_val[up_ch] = lracl;
            end
            for (int i = 0; i < 6; i++) begin
                if (kon[i])  kon_cnt[i]++;
                if (koff[i]) koff_cnt[i]++;
            end
        end
        exp_dout = rd_model(a);
        @(posedge clk);
        if (c && k >= 0) begin
            pend_m[k] = 0; kon_m[k] = 0; koff_m[k] = 0;
        end
        if (w) begin
            if (a == 8'h00) begin
                for (int i = 0; i < 6; i++)
                    if (d[i]) begin
                        if (d[7]) koff_m[i] = 1; else kon_m[i] = 1;
                    end
            end else if (a == 8'h01) atl_m = d[5:0];
            else if (a >= 8'h08 && a <= 8'h0D) begin
                sh_m[a - 8'h08] = d; pend_m[a - 8'h08] = 1;
            end
        end
        #1;
        chk("dout", dout, exp_dout);
        if (c) cur_ch = {cur_ch[4:0], cur_ch[5]};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h30, 8'h00);
    endtask

    // Stop just before the cen cycle that presents channel ch.
    task automatic goto_slot(input int ch);
        bit found;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (cur_ch == (6'd1 << ch) && phase == 2) found = 1;
            else idle(1);
        end
        chk("goto_slot", found, 1);
    endtask

    initial begin
        int r, sum;
        logic [7:0] a;
        npass = 0; ntot = 0; phase = 0;
        rst_n = 1'b0; cen = 1'b0; we = 1'b0; addr = 8'h00; din = 8'h00;
        cur_ch = 6'b000001;
        model_reset();
        clr_counts();
        #12;
        chk("rst_up_ch", up_ch, 3'd7);
        chk("rst_atl", atl, 6'd0);
        chk("rst_pend", pend, 6'd0);
        chk("rst_kon", kon, 6'd0);
        chk("rst_koff", koff, 6'd0);
        chk("rst_lracl", lracl, 8'h00);
        chk("rst_dout", dout, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // idle 12 cen
        idle(36);

        // single shadow write delivered once in ch2's slot
        clr_counts();
        cyc(1'b1, 8'h0A, 8'hDF);
        idle(18);
        chk("ch2_deliv_cnt", del_cnt[2], 1);
        chk("ch2_deliv_val", del_val[2], 8'hDF);
        sum = 0;
        for (int i = 0; i < 6; i++) if (i != 2) sum += del_cnt[i];
        chk("other_deliv", sum, 0);
        chk("pend_after_ch2", pend, 6'd0);

        // key on ch0/ch5, key off ch2, two rotations
        clr_counts();
        cyc(1'b1, 8'h00, 8'h21);
        cyc(1'b1, 8'h00, 8'h84);
        idle(36);
        chk("kon_ch0", kon_cnt[0], 1);
        chk("kon_ch5", kon_cnt[5], 1);
        chk("koff_ch2", koff_cnt[2], 1);
        sum = 0;
        for (int i = 0; i < 6; i++) sum += kon_cnt[i] + koff_cnt[i];
        chk("key_total", sum, 3);

        // coalesced rewrite of ch5
        goto_slot(0);
        clr_counts();
        cyc(1'b1, 8'h0D, 8'h40);
        cyc(1'b1, 8'h0D, 8'hC5);
        idle(18);
        chk("ch5_deliv_cnt", del_cnt[5], 1);
        chk("ch5_deliv_val", del_val[5], 8'hC5);

        // write in the same clk as ch1's consuming cen
        goto_slot(1);
        cyc(1'b1, 8'h09, 8'h11);
        chk("ch1_pend_kept", pend[1], 1'b1);
        clr_counts();
        idle(18);
        chk("ch1_deliv_cnt", del_cnt[1], 1);
        chk("ch1_deliv_val", del_val[1], 8'h11);

        // invalid cur_ch: no delivery and no consumption
        cyc(1'b1, 8'h08, 8'h55);
        cur_ch = 6'b000000;
        idle(6);
        cur_ch = 6'b000011;
        idle(6);
        chk("inv_pend0", pend[0], 1'b1);
        cur_ch = 6'b000001;
        idle(24);

        // randomized writes
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = 8'h00;
            else if (r == 1) a = 8'h01;
            else if (r <= 7) a = 8'h08 + 8'(r - 2);
            else a = 8'($urandom);
            cyc(($urandom_range(0, 3) == 0), a, 8'($urandom));
        end
        idle(18);

        // pending mix then asynchronous reset
        goto_slot(0);
        idle(1);
        cyc(1'b1, 8'h0D, 8'hA5);
        cyc(1'b1, 8'h0B, 8'h5A);
        cyc(1'b1, 8'h09, 8'h3C);
        chk("pend_101010", pend, 6'b101010);
        cyc(1'b1, 8'h01, 8'h3F);
        cyc(1'b0, 8'h01, 8'h00);
        chk("atl_3f", atl, 6'h3F);
`ifdef JT10_ADPCM_RDBACK_EN
        chk("rd_atl", dout, 8'h3F);
`endif
        cyc(1'b0, 8'h30, 8'h00);
`ifdef JT10_ADPCM_RDBACK_EN
        chk("rd_unmapped", dout, 8'hFF);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_atl", atl, 6'd0);
        chk("arst_pend", pend, 6'd0);
        chk("arst_up_ch", up_ch, 3'd7);
        chk("arst_kon", kon, 6'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(18);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/jt10_adpcm_regwr.md
Name: jt10_adpcm_regwr

Overview:
- CPU-side writer for the ADPCM-A channel control registers.
- Decodes byte writes for total level, per-channel L/R + level, and key on/off.
- Holds each update as pending, then delivers it to the 6-slot channel pipeline, with its one-hot cur_ch, in the exact slot its channel occupies.
- Feeds the ADPCM gain stage (atl, lracl, up_ch) and the ADPCM-A key logic (kon/koff).

Parameters:
- NCH, 6, number of ADPCM-A channels; fixed by the 6-slot pipeline, not to be changed.
- UP_IDLE, 3'd7, up_ch value meaning "no update"; decodes to no channel.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low; clock clk
- cen  in  1  pipeline clock enable (666 kHz rate)
- cur_ch  in  6  one-hot current pipeline slot; rotates left once per cen
- addr  in  8  ADPCM-A register address
- din  in  8  write data
- we  in  1  write strobe; one clk cycle per write, independent of cen
- atl  out  6  total level; registered
- lracl  out  8  {L,R,unused,level[4:0]} for the channel in up_ch; combinational from shadow
- up_ch  out  3  binary channel being updated this slot; UP_IDLE when none
- kon  out  6  one-hot key-on strobe aligned to cur_ch; valid for one cen slot
- koff  out  6  one-hot key-off strobe aligned to cur_ch
- pend  out  6  pending-update mask, for debug and verification
- dout  out  8  readback data (only with the optional feature)

Behaviour:
- Reset:
  - atl=0; all six shadow lracl=8'h00.
  - pend=0; kon/koff pending masks=0.
  - up_ch=UP_IDLE; lracl=0; kon=koff=0; dout=0.
- Address decode, on a clk edge with we=1 (ignores cen):
  - 0x00: din[7]=0 → set kon_pend |= din[5:0]. din[7]=1 → set koff_pend |= din[5:0].
  - 0x01: atl <= din[5:0]; takes effect on the next clk.
  - 0x08..0x0D: shadow[addr-8] <= din; pend[addr-8] <= 1.
  - Any other address: ignored; no state change.
- Delivery, combinational per slot:
  - k = index of the set bit of cur_ch.
  - pend[k]=1 → up_ch=k, lracl=shadow[k]. Otherwise up_ch=UP_IDLE, lracl=shadow[k].
  - kon = cur_ch & kon_pend; koff = cur_ch & koff_pend.
- Consumption, on a clk edge with cen=1: clear pend[k], kon_pend[k] and koff_pend[k] for the slot just presented.
- Latency:
  - A write reaches the gain stage at the first cen whose cur_ch selects that channel, at least one clk after the write.
  - Worst case is 6 cen periods plus one clk.
- Simultaneous write and consume, same clk, same channel:
  - The write wins: shadow takes the new value and pend/kon_pend/koff_pend stay set.
  - The new data is delivered on the next visit; the old value may already have been delivered.
- Rewrite while pending: shadow is overwritten, pend stays 1, and only the last value is delivered (coalesced).
- Key on and key off in the same pending window:
  - Both strobes are issued in the same slot.
  - Downstream gives koff priority; this block does not arbitrate.
- cur_ch invalid (0 or multi-hot):
  - up_ch=UP_IDLE, kon=koff=0, no consumption.
  - Multi-hot detection is a popcount≠1 check.
- rst_n asserted mid-operation: everything returns to reset values asynchronously and pending updates are lost.

Optional Feature:
- Macro: JT10_ADPCM_RDBACK_EN.
- Defined:
  - dout is registered on every clk.
  - addr 0x01 → {2'b0, atl}; 0x08..0x0D → shadow[addr-8]; 0x00 → {2'b0, kon_pend | koff_pend}; other addresses → 8'hFF.
- Undefined: dout is tied to 8'h00 and no readback mux is built.

Test Plan:
- Reset, then idle 12 cen → up_ch=7, kon=koff=0, pend=0, atl=0 throughout.
- Write 0x0A=0xDF, then wait for cur_ch=6'b000100 → exactly one cen slot with up_ch=2 and lracl=0xDF; pend[2] clears after it; other slots show up_ch=7.
- Write 0x00=0x21, then 0x00=0x84 → kon pulses in the slots of ch0 and ch5, koff in the slot of ch2, one cen each; never repeated on the next rotation.
- Write 0x0D=0x40, then 0x0D=0xC5 before ch5's slot → single delivery with lracl=0xC5.
- Write 0x09=0x11 in the same clk as the cen consuming ch1 → pend[1] remains 1; next visit delivers 0x11.
- Write 0x01=0x3F, then assert rst_n low mid-rotation with pend=6'b101010 → atl=0x3F before reset; after reset atl=0, pend=0, up_ch=7. With JT10_ADPCM_RDBACK_EN, reading 0x01 before reset returns 0x3F and reading 0x30 returns 0xFF.
